// File: rtl/sel_scheduler.sv
// Round-robin ownership of a shared one-hot decoder among 3 requesters; grant registered 1 cycle after req seen in IDLE.
// An ownership ends on done, on the owner's req dropping, or after MAXHOLD cycles; RELEASE+IDLE idle cycles follow.
module sel_scheduler #(
  parameter int MAXHOLD = 8,
  parameter int D1      = 1
) (
  input  logic       ck,
  input  logic       res,
  input  logic [2:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       tout
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

  // D1 only ever modelled a simulation output delay; outputs here change at the clock edge.
  if (D1 < 0) begin : g_d1_negative
  end

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] last, last_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] gnt_nxt;
  logic       busy_nxt, tout_nxt;
  logic [1:0] c0, c1, c2, winner;
  logic       win_vld, owner_req, expire;

  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic req_of(input logic [2:0] r, input logic [1:0] i);
    case (i)
      2'd0:    return r[0];
      2'd1:    return r[1];
      2'd2:    return r[2];
      default: return 1'b0;
    endcase
  endfunction

  // Search order starts just after the most recent owner.
  always_comb begin
    c0      = rr_next(last);
    c1      = rr_next(c0);
    c2      = rr_next(c1);
    win_vld = |req;
    winner  = c2;
    if (req_of(req, c0))      winner = c0;
    else if (req_of(req, c1)) winner = c1;
  end

  assign owner_req = req_of(req, sel);
  assign expire    = (cnt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = 8'd0;
    last_nxt  = last;
    sel_nxt   = 2'b11;
    gnt_nxt   = 4'b1000;
    busy_nxt  = 1'b0;
    tout_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          gnt_nxt   = 4'b0001 << winner;
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (done || !owner_req || expire) begin
          state_nxt = RELEASE;
          last_nxt  = sel;
          // done takes precedence over expiry
          tout_nxt  = expire && !done && owner_req;
        end else begin
          cnt_nxt  = cnt + 8'd1;
          sel_nxt  = sel;
          gnt_nxt  = gnt;
          busy_nxt = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state <= IDLE;
      cnt   <= 8'd0;
      last  <= 2'd2;
      sel   <= 2'b11;
      gnt   <= 4'b1000;
      busy  <= 1'b0;
      tout  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
      sel   <= sel_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      tout  <= tout_nxt;
    end
  end

endmodule
